traffic_phase_sequencer: RTL and testbench
==========================================

# traffic_phase_sequencer

Parametrised multi-phase traffic-signal sequencer. It drives NUM_CH three-lamp signal heads (vehicle and pedestrian) through NUM_PHASES programmable green phases. Each phase is followed by a yellow interval and an all-red clearance. The block adds per-phase run-time durations, demand-driven phase skipping and a night flashing-yellow mode. It sits between the 1 Hz tick generator and the lamp driver outputs of the intersection controller.

## Interface
- NUM_PHASES, 4: number of green phases; must be 2..16.
- NUM_CH, 14: number of signal heads.
- TW, 6: width of each duration field, in ticks.
- PW, 4: phase index width; must satisfy 2^PW >= NUM_PHASES.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- tick  in  1  one-clk enable pulse; all timing counts ticks.
- phase_mask  in  NUM_PHASES*NUM_CH  field p holds the channels green in phase p.
- green_time  in  NUM_PHASES*TW  field p is the green duration of phase p.
- yellow_time  in  TW  common yellow duration.
- allred_time  in  TW  common all-red duration.
- demand  in  NUM_PHASES  level or pulse call per phase; bit 0 is ignored.
- skip_en  in  1  1 = phases 1..N-1 without latched demand are skipped.
- night  in  1  request flashing mode.
- lights  out  NUM_CH*3  per channel, field c: 100 red, 010 yellow, 001 green, 000 dark.
- phase  out  PW  current phase index.
- state  out  2  0 ALLRED, 1 GREEN, 2 YELLOW, 3 FLASH.
- phase_start  out  1  one-clk pulse on the cycle GREEN is entered.

## Operation
- Registers: st, cur (phase), cnt[TW], dem_q[NUM_PHASES], blink.
- Durations: an effective duration d = max(field, 1). A state lasts exactly d ticks. On a tick with cnt == d-1, the block transitions and sets cnt to 0; on any other tick, cnt increments.
- GREEN(cur) -> YELLOW(cur) -> ALLRED -> next. Here next is FLASH if night = 1; otherwise GREEN(sel).
- sel is the first phase in circular order cur+1, cur+2, … that is eligible. Phase 0 is always eligible. Phase p≠0 is eligible if skip_en = 0, or dem_q[p] = 1, or demand[p] = 1 on the same cycle. The search always terminates at phase 0 at the latest.
- dem_q[p] is set by demand[p] on any clk and cleared on entry to GREEN(p). If set and clear coincide, the clear wins.
- The night input is sampled only at the end of ALLRED, so no green or yellow is ever truncated.
- FLASH: blink toggles on every tick. Every channel shows 010 when blink = 1 and 000 when blink = 0. When night is deasserted on a tick, the block goes to ALLRED with cnt = 0 and cur = NUM_PHASES-1, so the next green is phase 0.
- Lamp decode is combinational from registered st, cur and blink:
  - GREEN: channels in the mask show 001; all others show 100.
  - YELLOW: channels in the mask show 010; all others show 100.
  - ALLRED: all channels show 100.
- Changes to the config inputs take effect at the next comparison; the integrator keeps them stable within a cycle of operation.

## Timing
- Reset (async): st = ALLRED, cur = NUM_PHASES-1, cnt = 0, dem_q = 0, blink = 0.
- Output values in reset: lights all 100, phase = NUM_PHASES-1, state = 0, phase_start = 0.
- First green after reset: phase 0, entered on the allred_time-th tick.
- State, phase and lights change on the clk edge that samples the terminating tick, with zero added latency. phase_start is registered and asserts in that same cycle.
- No transition occurs without tick. Reset mid-phase aborts immediately into all-red.
- Full cycle length with no skips: sum of the effective green durations plus NUM_PHASES*(yellow + allred) ticks.

## Test plan
- Bench configuration: NUM_PHASES = 3, NUM_CH = 4; masks p0 = 0011, p1 = 0100, p2 = 1000; green = 5, 3, 2; yellow = 2; allred = 1.
- Reset, then run ticks -> ALLRED for 1 tick, then GREEN0 with lights ch0/ch1 = 001 and ch2/ch3 = 100 for 5 ticks, then YELLOW0 with ch0/ch1 = 010 for 2 ticks, then ALLRED, then GREEN1, GREEN2, GREEN0; period 19 ticks; one phase_start per green.
- skip_en = 1, demand = 0 -> sequence is GREEN0 -> YELLOW -> ALLRED -> GREEN0 (period 8 ticks). Pulse demand[2] for one clk during GREEN0 -> next green is phase 2, and dem_q[2] clears on entry.
- Set yellow_time = 0 -> yellow lasts exactly 1 tick. Hold tick low for 100 clks -> no state change.
- Assert night during GREEN1 -> green and yellow complete, then FLASH follows the all-red. Lights alternate 010/000 each tick. Deassert night -> ALLRED for 1 tick, then GREEN0.
- Assert rst in the middle of YELLOW2 -> lights immediately show all 100, state = 0, phase = 2, dem_q cleared; recovery follows the first scenario.

Source files
------------

// File: rtl/traffic_phase_sequencer.sv
// Multi-phase traffic-signal sequencer: green/yellow/all-red rotation with
// demand-driven phase skipping and a night flashing-yellow mode.
module traffic_phase_sequencer #(
  parameter int NUM_PHASES = 4,
  parameter int NUM_CH     = 14,
  parameter int TW         = 6,
  parameter int PW         = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         tick,
  input  logic [NUM_PHASES*NUM_CH-1:0] phase_mask,
  input  logic [NUM_PHASES*TW-1:0]     green_time,
  input  logic [TW-1:0]                yellow_time,
  input  logic [TW-1:0]                allred_time,
  input  logic [NUM_PHASES-1:0]        demand,
  input  logic                         skip_en,
  input  logic                         night,
  output logic [NUM_CH*3-1:0]          lights,
  output logic [PW-1:0]                phase,
  output logic [1:0]                   state,
  output logic                         phase_start
);

  typedef enum logic [1:0] {
    ALLRED = 2'd0,
    GREEN  = 2'd1,
    YELLOW = 2'd2,
    FLASH  = 2'd3
  } st_t;

  localparam logic [PW-1:0] LAST = PW'(NUM_PHASES - 1);
  localparam logic [NUM_PHASES-1:0] ONE = NUM_PHASES'(1);

  st_t                   st, st_n;
  logic [PW-1:0]         cur, cur_n;
  logic [TW-1:0]         cnt, cnt_n;
  logic [NUM_PHASES-1:0] dem_q, dem_n;
  logic                  blink, blink_n;
  logic                  ps_n;

  logic [TW-1:0]         green_cur;
  logic [NUM_CH-1:0]     mask_cur;
  logic [TW-1:0]         dur;
  logic                  last;
  logic [NUM_PHASES-1:0] elig;
  logic [PW-1:0]         sel;

  function automatic logic [TW-1:0] eff(input logic [TW-1:0] f);
    return (f == '0) ? TW'(1) : f;
  endfunction

  assign green_cur = TW'(green_time >> (cur * TW));
  assign mask_cur  = NUM_CH'(phase_mask >> (cur * NUM_CH));

  always_comb begin
    dur = eff(allred_time);
    unique case (st)
      GREEN:   dur = eff(green_cur);
      YELLOW:  dur = eff(yellow_time);
      default: dur = eff(allred_time);
    endcase
  end

  assign last = tick && (cnt == dur - TW'(1));

  // Phase 0 is always eligible, so the circular search always lands.
  assign elig = skip_en ? (dem_q | demand | ONE) : '1;

  always_comb begin
    logic [NUM_PHASES-1:0] rot;
    logic                  found;
    int                    p;
    rot   = '0;
    found = 1'b0;
    p     = 0;
    sel   = '0;
    for (int i = 1; i <= NUM_PHASES; i++) begin
      p = int'(cur) + i;
      if (p >= NUM_PHASES) p = p - NUM_PHASES;
      rot = elig >> p;
      if (!found && rot[0]) begin
        sel   = PW'(p);
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st          <= ALLRED;
      cur         <= LAST;
      cnt         <= '0;
      dem_q       <= '0;
      blink       <= 1'b0;
      phase_start <= 1'b0;
    end else begin
      st          <= st_n;
      cur         <= cur_n;
      cnt         <= cnt_n;
      dem_q       <= dem_n;
      blink       <= blink_n;
      phase_start <= ps_n;
    end
  end

  always_comb begin
    st_n    = st;
    cur_n   = cur;
    cnt_n   = cnt;
    blink_n = blink;
    ps_n    = 1'b0;
    dem_n   = dem_q | (demand & ~ONE);
    if (tick) begin
      unique case (st)
        FLASH: begin
          blink_n = ~blink;
          if (!night) begin
            st_n    = ALLRED;
            cur_n   = LAST;
            cnt_n   = '0;
            blink_n = 1'b0;
          end
        end
        default: begin
          if (last) begin
            cnt_n = '0;
            unique case (st)
              GREEN:  st_n = YELLOW;
              YELLOW: st_n = ALLRED;
              default: begin
                if (night) begin
                  st_n = FLASH;
                end else begin
                  st_n  = GREEN;
                  cur_n = sel;
                  ps_n  = 1'b1;
                  dem_n = dem_n & ~(ONE << sel);
                end
              end
            endcase
          end else begin
            cnt_n = cnt + TW'(1);
          end
        end
      endcase
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [2:0] lamp;
    always_comb begin
      lamp = 3'b100;
      unique case (st)
        GREEN:   lamp = mask_cur[c] ? 3'b001 : 3'b100;
        YELLOW:  lamp = mask_cur[c] ? 3'b010 : 3'b100;
        FLASH:   lamp = blink ? 3'b010 : 3'b000;
        default: lamp = 3'b100;
      endcase
    end
    assign lights[3*c +: 3] = lamp;
  end

  assign phase = cur;
  assign state = st;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Directed bench for traffic_phase_sequencer: countdown-based reference
// model checked every cycle, plus hand-computed checkpoints.
module tb_traffic_phase_sequencer;

  localparam int N  = 3;
  localparam int CH = 4;
  localparam int TW = 6;
  localparam int PW = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              tick = 1'b0;
  logic [N*CH-1:0]   phase_mask = {4'b1000, 4'b0100, 4'b0011};
  logic [N*TW-1:0]   green_time = {6'd2, 6'd3, 6'd5};
  logic [TW-1:0]     yellow_time = 6'd2;
  logic [TW-1:0]     allred_time = 6'd1;
  logic [N-1:0]      demand = '0;
  logic              skip_en = 1'b0;
  logic              night = 1'b0;
  logic [CH*3-1:0]   lights;
  logic [PW-1:0]     phase;
  logic [1:0]        state;
  logic              phase_start;

  int errors = 0;
  int checks = 0;

  traffic_phase_sequencer #(
    .NUM_PHASES(N), .NUM_CH(CH), .TW(TW), .PW(PW)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick),
    .phase_mask(phase_mask), .green_time(green_time),
    .yellow_time(yellow_time), .allred_time(allred_time),
    .demand(demand), .skip_en(skip_en), .night(night),
    .lights(lights), .phase(phase), .state(state),
    .phase_start(phase_start)
  );

  always #5 clk = ~clk;

  // Reference: rem counts ticks left in the current interval.
  typedef struct {
    int       st;
    int       ph;
    int       rem;
    bit [2:0] dem;
    bit       blink;
    bit       start;
  } m_t;

  m_t m;

  function automatic int dur(input logic [TW-1:0] f);
    return (f == 0) ? 1 : int'(f);
  endfunction

  function automatic m_t reset_m();
    m_t r;
    r.st = 0; r.ph = N - 1; r.rem = dur(allred_time);
    r.dem = '0; r.blink = 0; r.start = 0;
    return r;
  endfunction

  function automatic m_t step_m(input m_t o);
    m_t n;
    bit [2:0] nd;
    int p;
    n = o;
    n.start = 0;
    nd = o.dem | (demand & 3'b110);
    if (tick) begin
      if (o.st == 3) begin
        n.blink = !o.blink;
        if (!night) begin
          n.st = 0; n.ph = N - 1; n.rem = dur(allred_time); n.blink = 0;
        end
      end else if (o.rem > 1) begin
        n.rem = o.rem - 1;
      end else if (o.st == 1) begin
        n.st = 2; n.rem = dur(yellow_time);
      end else if (o.st == 2) begin
        n.st = 0; n.rem = dur(allred_time);
      end else if (night) begin
        n.st = 3;
      end else begin
        p = 0;
        for (int k = 1; k <= N; k++) begin
          p = (o.ph + k) % N;
          if (p == 0 || !skip_en || nd[p]) break;
        end
        n.st = 1; n.ph = p; n.start = 1;
        n.rem = dur(green_time[p*TW +: TW]);
        nd[p] = 0;
      end
    end
    n.dem = nd;
    return n;
  endfunction

  function automatic logic [CH*3-1:0] exp_lights(input m_t s);
    logic [CH*3-1:0] l;
    logic [CH-1:0] mk;
    mk = phase_mask[s.ph*CH +: CH];
    for (int c = 0; c < CH; c++) begin
      case (s.st)
        1:       l[3*c +: 3] = mk[c] ? 3'b001 : 3'b100;
        2:       l[3*c +: 3] = mk[c] ? 3'b010 : 3'b100;
        3:       l[3*c +: 3] = s.blink ? 3'b010 : 3'b000;
        default: l[3*c +: 3] = 3'b100;
      endcase
    end
    return l;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m <= reset_m();
    else     m <= step_m(m);
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model_lights", 32'(lights), 32'(exp_lights(m)));
    chk("model_phase", 32'(phase), 32'(m.ph));
    chk("model_state", 32'(state), 32'(m.st));
    chk("model_start", 32'(phase_start), 32'(m.start));
  end

  task automatic tk(input int n);
    repeat (n) begin
      tick = 1'b1;
      @(posedge clk);
      #1 tick = 1'b0;
    end
  endtask

  // Tick until phase_start for phase 'want'; n = ticks, s = starts seen.
  task automatic run_to(input int want, output int n, output int s);
    n = 0;
    s = 0;
    while (n < 60) begin
      tk(1);
      n++;
      if (phase_start) begin
        s++;
        if (int'(phase) == want) return;
      end
    end
    checks++;
    errors++;
    $display("FAIL run_to_timeout: phase %0d not started within 60 ticks",
             want);
  endtask

  localparam logic [11:0] ALL_RED = 12'b100_100_100_100;
  localparam logic [11:0] G0      = 12'b100_100_001_001;
  localparam logic [11:0] Y0      = 12'b100_100_010_010;
  localparam logic [11:0] G1      = 12'b100_001_100_100;
  localparam logic [11:0] FL_ON   = 12'b010_010_010_010;

  initial begin
    int n, s;
    logic [11:0] l_hold;
    logic [1:0]  st_hold;
    logic [1:0]  ph_hold;

    @(posedge clk);
    #1;
    chk("rst_lights", 32'(lights), 32'(ALL_RED));
    chk("rst_phase", 32'(phase), 32'd2);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_start", 32'(phase_start), 32'd0);
    rst = 1'b0;

    // Basic rotation
    tk(1);
    chk("g0_state", 32'(state), 32'd1);
    chk("g0_phase", 32'(phase), 32'd0);
    chk("g0_start", 32'(phase_start), 32'd1);
    chk("g0_lights", 32'(lights), 32'(G0));
    run_to(0, n, s);
    chk("period_ticks", n, 19);
    chk("period_starts", s, 3);
    tk(5);
    chk("y0_state", 32'(state), 32'd2);
    chk("y0_lights", 32'(lights), 32'(Y0));
    tk(2);
    chk("ar_state", 32'(state), 32'd0);
    tk(1);
    chk("g1_phase", 32'(phase), 32'd1);
    chk("g1_lights", 32'(lights), 32'(G1));

    // Skipping with demand
    skip_en = 1'b1;
    run_to(0, n, s);
    chk("skip_to0_ticks", n, 6);
    run_to(0, n, s);
    chk("skip_period", n, 8);
    chk("skip_starts", s, 1);
    tk(1);
    demand = 3'b100;
    @(posedge clk);
    #1 demand = 3'b000;
    run_to(2, n, s);
    chk("dem2_ticks", n, 7);
    chk("dem2_starts", s, 1);
    run_to(0, n, s);
    chk("dem2_cleared", n, 5);
    chk("dem2_cl_starts", s, 1);

    // Zero yellow, idle without tick
    yellow_time = 6'd0;
    tk(5);
    chk("y_zero_in", 32'(state), 32'd2);
    tk(1);
    chk("y_zero_out", 32'(state), 32'd0);
    l_hold = lights;
    st_hold = state;
    ph_hold = phase;
    repeat (100) @(posedge clk);
    #1;
    chk("idle_lights", 32'(lights), 32'(l_hold));
    chk("idle_state", 32'(state), 32'(st_hold));
    chk("idle_phase", 32'(phase), 32'(ph_hold));
    yellow_time = 6'd2;
    skip_en = 1'b0;
    tk(1);
    chk("resume_g1", 32'(phase), 32'd1);
    chk("resume_st", 32'(state), 32'd1);

    // Night mode
    night = 1'b1;
    tk(2);
    chk("night_green", 32'(state), 32'd1);
    tk(1);
    chk("night_yellow", 32'(state), 32'd2);
    tk(2);
    chk("night_allred", 32'(state), 32'd0);
    tk(1);
    chk("flash_state", 32'(state), 32'd3);
    chk("flash_off", 32'(lights), 32'd0);
    tk(1);
    chk("flash_on", 32'(lights), 32'(FL_ON));
    tk(1);
    chk("flash_off2", 32'(lights), 32'd0);
    night = 1'b0;
    tk(1);
    chk("exit_state", 32'(state), 32'd0);
    chk("exit_phase", 32'(phase), 32'd2);
    tk(1);
    chk("exit_g0", 32'(phase), 32'd0);
    chk("exit_g0_st", 32'(state), 32'd1);

    // Reset mid-yellow
    run_to(1, n, s);
    chk("to_g1", n, 8);
    run_to(2, n, s);
    chk("to_g2", n, 6);
    tk(2);
    chk("y2_state", 32'(state), 32'd2);
    chk("y2_phase", 32'(phase), 32'd2);
    demand = 3'b010;
    @(posedge clk);
    #1 demand = 3'b000;
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_lights", 32'(lights), 32'(ALL_RED));
    chk("mid_rst_state", 32'(state), 32'd0);
    chk("mid_rst_phase", 32'(phase), 32'd2);
    @(posedge clk);
    #1 rst = 1'b0;
    skip_en = 1'b1;
    tk(1);
    chk("rec_g0", 32'(phase), 32'd0);
    chk("rec_start", 32'(phase_start), 32'd1);
    run_to(0, n, s);
    chk("rec_dem_clr", n, 8);
    chk("rec_dem_starts", s, 1);
    skip_en = 1'b0;
    run_to(1, n, s);
    chk("rec_g1", n, 8);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
